// File: rtl/stack_arbiter.sv
// Round-robin arbiter/sequencer that gives two requesters push/pop access to a shared LIFO stack.
// The block tracks stack occupancy itself and rejects overflow and underflow before the stack sees them.
module stack_arbiter #(
  parameter int DW    = 10,
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          op0,
  input  logic          op1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] dout0,
  output logic [DW-1:0] dout1,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_e;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_e        state_q, state_d;
  logic          lp_q, lp_d;
  logic          win_q, win_d;
  logic          op_q, op_d;
  logic [DW-1:0] din_q, din_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dout0_q, dout0_d;
  logic [DW-1:0] dout1_q, dout1_d;

  logic          pick;
  logic          pick_op;
  logic [DW-1:0] pick_din;

  // Under contention the port that was not served last wins.
  assign pick     = (req0 && req1) ? ~lp_q : req1;
  assign pick_op  = pick ? op1 : op0;
  assign pick_din = pick ? din1 : din0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lp_q    <= 1'b1;
      win_q   <= 1'b0;
      op_q    <= 1'b0;
      din_q   <= '0;
      count_q <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      win_q   <= win_d;
      op_q    <= op_d;
      din_q   <= din_d;
      count_q <= count_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lp_d    = lp_q;
    win_d   = win_q;
    op_d    = op_q;
    din_d   = din_q;
    count_d = count_q;
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d = pick;
          op_d  = pick_op;
          din_d = pick_din;
          // Legality uses the registered full/empty; this is the only overflow/underflow guard.
          if (pick_op ? !full : !empty) state_d = ISSUE;
          else                          state_d = ERR;
        end
      end
      ISSUE: begin
        if (op_q) begin
          count_d = count_q + CW'(1);
          state_d = DONE;
        end else begin
          count_d = count_q - CW'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (win_q) dout1_d = stk_dout;
        else       dout0_d = stk_dout;
        state_d = DONE;
      end
      DONE, ERR: begin
        lp_d    = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stk_push = (state_q == ISSUE) && op_q;
  assign stk_pop  = (state_q == ISSUE) && !op_q;
  assign stk_din  = stk_push ? din_q : '0;

  assign ack0  = ((state_q == DONE) || (state_q == ERR)) && !win_q;
  assign ack1  = ((state_q == DONE) || (state_q == ERR)) && win_q;
  assign err0  = (state_q == ERR) && !win_q;
  assign err1  = (state_q == ERR) && win_q;
  assign dout0 = dout0_q;
  assign dout1 = dout1_q;

  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: table-driven transactions with a scoreboard queue,
// a behavioural 16x10 LIFO standing in for the real stack, and hand-written corner sequences.
module tb_stack_arbiter;

  localparam int DW = 10;
  localparam int DEPTH = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          op0 = 1'b0, op1 = 1'b0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] dout0, dout1;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_dout;
  logic [CW-1:0] count;
  logic          full, empty;

  stack_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1), .din0(din0), .din1(din1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .dout0(dout0), .dout1(dout1),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    bit            op;
    logic [DW-1:0] din;
    bit            expErr;
    logic [DW-1:0] expDout;
    int            expCount;
    int            expLat;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  vec_t          sbQ[$];
  vec_t          vecs[22];
  logic [DW-1:0] modelDout[2];
  int            pushPulses = 0;
  int            popPulses = 0;
  logic [DW-1:0] lastStkDin = '0;
  bit            strobePrev = 1'b0;

  // Behavioural stack: push writes on the strobe edge, pop data appears the cycle after stk_pop.
  logic [DW-1:0] mem[DEPTH];
  int            sp = 0;
  always @(posedge clk) begin
    if (reset) begin
      sp <= 0;
      stk_dout <= '0;
    end else if (stk_push) begin
      if (sp < DEPTH) mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop) begin
      if (sp > 0) stk_dout <= mem[sp-1];
      sp <= sp - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Strobe monitor: no simultaneous push/pop and no strobe lasting more than one cycle.
  always @(negedge clk) begin
    if (reset) begin
      strobePrev = 1'b0;
    end else begin
      if (stk_push) begin
        pushPulses++;
        lastStkDin = stk_din;
      end
      if (stk_pop) popPulses++;
      if (stk_push || stk_pop) begin
        checkOutput("strobe_exclusive", {31'd0, stk_push && stk_pop}, 32'd0);
        checkOutput("strobe_single_cycle", {31'd0, strobePrev}, 32'd0);
      end
      strobePrev = stk_push || stk_pop;
    end
  end

  task automatic doReset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelDout[0] = '0;
    modelDout[1] = '0;
  endtask

  // Drive one transaction in an IDLE cycle, wait for its ack, then score it against the queue head.
  task automatic applyStimulus(input vec_t v);
    int   lat;
    bit   seen;
    bit   otherAck;
    vec_t e;
    pushPulses = 0;
    popPulses = 0;
    lastStkDin = '0;
    sbQ.push_back(v);
    if (v.port == 0) begin
      req0 = 1'b1; op0 = v.op; din0 = v.din;
    end else begin
      req1 = 1'b1; op1 = v.op; din1 = v.din;
    end
    seen = 1'b0;
    otherAck = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat = i;
      if ((v.port == 0) ? ack0 : ack1) seen = 1'b1;
      else if ((v.port == 0) ? ack1 : ack0) otherAck = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_timeout: port %0d got no ack, required one within 12 cycles", v.port);
      void'(sbQ.pop_front());
    end else begin
      e = sbQ.pop_front();
      checkOutput("latency", lat, e.expLat);
      checkOutput("err", {31'd0, (e.port == 0) ? err0 : err1}, {31'd0, e.expErr});
      checkOutput("other_port_quiet", {31'd0, otherAck}, 32'd0);
      checkOutput("count", {27'd0, count}, e.expCount);
      checkOutput("full", {31'd0, full}, {31'd0, e.expCount == DEPTH});
      checkOutput("empty", {31'd0, empty}, {31'd0, e.expCount == 0});
      checkOutput("push_pulses", pushPulses, (e.op && !e.expErr) ? 1 : 0);
      checkOutput("pop_pulses", popPulses, (!e.op && !e.expErr) ? 1 : 0);
      if (e.op && !e.expErr) checkOutput("stk_din", {22'd0, lastStkDin}, {22'd0, e.din});
      if (!e.op && !e.expErr) modelDout[e.port] = e.expDout;
      checkOutput("dout0", {22'd0, dout0}, {22'd0, modelDout[0]});
      checkOutput("dout1", {22'd0, dout1}, {22'd0, modelDout[1]});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   grantQ[$];
    int   acks;
    int   p;
    bit   bothAck;
    vec_t v;

    vecs[0] = '{port: 0, op: 1'b1, din: 10'h155, expErr: 1'b0, expDout: 10'h000, expCount: 1, expLat: 2};
    vecs[1] = '{port: 1, op: 1'b0, din: 10'h000, expErr: 1'b0, expDout: 10'h155, expCount: 0, expLat: 3};
    vecs[2] = '{port: 0, op: 1'b0, din: 10'h000, expErr: 1'b1, expDout: 10'h000, expCount: 0, expLat: 1};
    for (int i = 0; i < DEPTH; i++)
      vecs[3+i] = '{port: 0, op: 1'b1, din: 10'h200 + 10'(i), expErr: 1'b0, expDout: 10'h000, expCount: i + 1, expLat: 2};
    vecs[19] = '{port: 0, op: 1'b1, din: 10'h3FF, expErr: 1'b1, expDout: 10'h000, expCount: 16, expLat: 1};
    vecs[20] = '{port: 1, op: 1'b0, din: 10'h000, expErr: 1'b0, expDout: 10'h20F, expCount: 15, expLat: 3};
    vecs[21] = '{port: 0, op: 1'b0, din: 10'h000, expErr: 1'b0, expDout: 10'h20E, expCount: 14, expLat: 3};

    doReset();
    checkOutput("reset_count", {27'd0, count}, 32'd0);
    checkOutput("reset_full", {31'd0, full}, 32'd0);
    checkOutput("reset_empty", {31'd0, empty}, 32'd1);
    checkOutput("reset_acks", {28'd0, ack0, ack1, err0, err1}, 32'd0);
    checkOutput("reset_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
    checkOutput("reset_stk_din", {22'd0, stk_din}, 32'd0);
    checkOutput("reset_douts", {12'd0, dout0, dout1}, 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset during WAIT of a pop: the transaction is dropped with no ack and all state cleared.
    doReset();
    v = '{port: 0, op: 1'b1, din: 10'h123, expErr: 1'b0, expDout: 10'h000, expCount: 1, expLat: 2};
    applyStimulus(v);
    v = '{port: 0, op: 1'b0, din: 10'h000, expErr: 1'b0, expDout: 10'h123, expCount: 0, expLat: 3};
    applyStimulus(v);
    v = '{port: 0, op: 1'b1, din: 10'h0AA, expErr: 1'b0, expDout: 10'h000, expCount: 1, expLat: 2};
    applyStimulus(v);
    v = '{port: 0, op: 1'b1, din: 10'h0BB, expErr: 1'b0, expDout: 10'h000, expCount: 2, expLat: 2};
    applyStimulus(v);
    req0 = 1'b1; op0 = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_issue_pop", {31'd0, stk_pop}, 32'd1);
    @(posedge clk); #1;
    checkOutput("midreset_wait_count", {27'd0, count}, 32'd1);
    reset = 1'b1;
    req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_ack0", {31'd0, ack0}, 32'd0);
    checkOutput("midreset_dout0", {22'd0, dout0}, 32'd0);
    checkOutput("midreset_count", {27'd0, count}, 32'd0);
    checkOutput("midreset_empty", {31'd0, empty}, 32'd1);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack0 || ack1 || stk_push || stk_pop) acks++;
    end
    checkOutput("midreset_no_late_activity", acks, 32'd0);

    // Both ports held with pushes: grants alternate starting with port 0.
    doReset();
    grantQ = '{0, 1, 0, 1};
    req0 = 1'b1; op0 = 1'b1; din0 = 10'h0A1;
    req1 = 1'b1; op1 = 1'b1; din1 = 10'h0B2;
    acks = 0;
    bothAck = 1'b0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(posedge clk); #1;
      if (ack0 && ack1) bothAck = 1'b1;
      else if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        checkOutput("grant_port", p, grantQ.pop_front());
        checkOutput("grant_stk_din", {22'd0, lastStkDin}, (p == 1) ? 32'h0B2 : 32'h0A1);
        acks++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("grant_both_ack", {31'd0, bothAck}, 32'd0);
    checkOutput("grant_count", acks, 32'd4);
    checkOutput("grant_occupancy", {27'd0, count}, 32'd4);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Two-port arbiter and sequencer for the shared 16-entry, 10-bit LIFO stack. Each of two requesters issues push or pop transactions through a req/ack handshake. The block grants them round-robin, drives the stack's push/pop strobes as single-cycle pulses, and tracks occupancy so overflow and underflow are rejected before they reach the stack. It sits between the requesting datapath units and the stack instance, and is the only driver of the stack's control inputs.

## Interface
- DW, 10: data width, matches the stack word
- DEPTH, 16: stack entries; CW = $clog2(DEPTH+1) = 5

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; same reset feeds the stack
- req0 / req1  in  1  transaction request, held until ack
- op0 / op1  in  1  1 = push, 0 = pop; stable while req high
- din0 / din1  in  DW  push data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  high together with ack when the transaction was rejected
- dout0 / dout1  out  DW  pop result; valid from ack cycle until that port's next pop completes
- stk_push  out  1  stack push strobe, one cycle
- stk_pop  out  1  stack pop strobe, one cycle
- stk_din  out  DW  data to stack, valid with stk_push
- stk_dout  in  DW  stack pop data, valid the cycle after stk_pop
- count  out  CW  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE, when any req is high:
  - Select a winner. If only one req is high, that port wins. If both are high, the port not served last wins (last-served pointer `lp`).
  - Latch the winner id, op and din.
  - Go to ISSUE if the op is legal: push with !full, or pop with !empty.
  - Otherwise go to ERR.
- ISSUE:
  - Push: stk_push = 1 and stk_din = latched din; count++; next state DONE.
  - Pop: stk_pop = 1; count--; next state WAIT.
- WAIT: capture stk_dout into the winner's dout register; next state DONE.
- DONE: ack of the winner = 1; `lp` = winner; next state IDLE.
- ERR: ack and err of the winner = 1; `lp` = winner; count unchanged; no stack strobe; next state IDLE.
- The non-winning port's request stays pending and is served on a later pass through IDLE. Its ack, err and dout are untouched meanwhile.
- Outputs are Moore decodes of registered state. stk_push and stk_pop are never high together, and never for more than one cycle.
- count is a CW-bit unsigned register that never wraps: the legality check in IDLE is the only guard, and it uses the registered full/empty.
- full and empty are combinational decodes of count.
- Requester rule: deassert req (or present the next transaction) in the cycle after ack. A req still high in IDLE is treated as a new transaction, so back-to-back transactions are intentional.

## Timing
- Request sampled at the edge ending IDLE cycle T. Latency from that edge:
  - Push: stk_push in T+1, ack in T+2.
  - Pop: stk_pop in T+1, capture in T+2, ack and dout valid in T+3.
  - Rejected: ack and err in T+1.
- Throughput: one push per 3 cycles, one pop per 4 cycles (IDLE included).
- count updates at the edge ending ISSUE, so full and empty reflect the new value from T+2.
- Reset values: state IDLE, `lp` = 1 (port 0 wins the first contention), count 0, full 0, empty 1, all ack/err/stk_push/stk_pop 0, stk_din 0, dout0/dout1 0.
- Reset mid-transaction: at the next edge everything returns to reset values. No ack is issued and the in-flight transaction is dropped. The stack resets to empty on the same edge, so count 0 stays consistent.

## Test plan
- After reset, req0 push 0x155 → stk_push high exactly 1 cycle with stk_din = 0x155; ack0 two cycles after request sampled; err0 = 0; count = 1.
- Pop from port 1 on the same stack → stk_pop pulse; ack1 three cycles after request sampled; dout1 = the stack's pop word; count = 0; empty = 1.
- Pop on empty from port 0 → ack0 and err0 high together one cycle after request sampled; no stk_pop; count stays 0.
- 16 pushes from port 0, then a 17th → the 17th gets err0 = 1, with no stk_push and count held at 16; then pop → count = 15, full = 0.
- req0 and req1 held continuously with pushes → grants alternate 0, 1, 0, 1 starting with port 0; neither port is starved.
- reset asserted during WAIT of a pop → next cycle state IDLE, no ack, dout unchanged from reset value 0, count = 0.
